// File: rtl/regfile_write_queue.sv
// Register-file write queue with optional read forwarding (REGFILE_WQ_FORWARD_EN); 1-cycle min latency.
// Backpressure: in_ready = !full from registered state; drains head to we3/wa3/wd3 when drain_en.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_en,
    output logic                     we3,
    output logic [AW-1:0]            wa3,
    output logic [DW-1:0]            wd3,
    input  logic [AW-1:0]            ra1,
    input  logic [AW-1:0]            ra2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [DW-1:0]            fwd1_data,
    output logic [DW-1:0]            fwd2_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

    // Register 0 is hardwired to zero: handshake completes but nothing is stored.
    assign push = in_valid && in_ready && (in_addr != '0);
    assign pop  = !empty && drain_en;

    assign we3 = pop;
    assign wa3 = empty ? '0 : addr_q[rd_ptr_q];
    assign wd3 = empty ? '0 : data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                addr_q[wr_ptr_q] <= in_addr;
                data_q[wr_ptr_q] <= in_data;
            end
        end
    end

`ifdef REGFILE_WQ_FORWARD_EN
    // Scan oldest to newest so a later match overrides an earlier one.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((ra1 != '0) && (addr_q[rd_ptr_q + PW'(i)] == ra1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_q[rd_ptr_q + PW'(i)];
                end
                if ((ra2 != '0) && (addr_q[rd_ptr_q + PW'(i)] == ra2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_q[rd_ptr_q + PW'(i)];
                end
            end
        end
    end
`else
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue; forwarding expectations follow REGFILE_WQ_FORWARD_EN.
module tb_regfile_write_queue;
`ifdef REGFILE_WQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_addr;
    logic [7:0] in_data;
    logic       drain_en;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [2:0] ra1, ra2;
    logic       fwd1_hit, fwd2_hit;
    logic [7:0] fwd1_data, fwd2_data;
    logic [2:0] count;
    logic       empty, full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] exp_q [$];
    logic [10:0] ent;

    regfile_write_queue #(.DEPTH(4), .DW(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .drain_en(drain_en), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        drain_en = 1'b0; ra1 = '0; ra2 = '0;
        #12;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_we3", we3, 0);
        check("rst_wa3", wa3, 0);
        check("rst_wd3", wd3, 0);
        check("rst_fwd1_hit", fwd1_hit, 0);
        check("rst_fwd2_hit", fwd2_hit, 0);
        check("rst_fwd1_data", fwd1_data, 0);
        check("rst_fwd2_data", fwd2_data, 0);
        rst_n = 1'b1;

        // Single push, held, then drained
        push(3'd3, 8'hA5);
        #1;
        check("t1_count", count, 1);
        check("t1_wa3", wa3, 3);
        check("t1_wd3", wd3, 8'hA5);
        check("t1_we3_hold", we3, 0);
        drain_en = 1'b1;
        #1;
        check("t1_we3_drain", we3, 1);
        tick();
        check("t1_empty", empty, 1);
        check("t1_we3_after", we3, 0);
        check("t1_wa3_empty", wa3, 0);
        drain_en = 1'b0;

        // Fill, reject fifth, drain in order
        for (int i = 1; i <= 4; i++) push(3'(i), 8'(i * 8'h11));
        check("fill_full", full, 1);
        check("fill_in_ready", in_ready, 0);
        check("fill_count", count, 4);
        push(3'd5, 8'h55);
        check("fill_fifth_count", count, 4);
        drain_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_we3", we3, 1);
            check("drain_wa3", wa3, i);
            check("drain_wd3", wd3, i * 8'h11);
            tick();
        end
        check("drain_empty", empty, 1);
        drain_en = 1'b0;

        // Forwarding priority
        push(3'd5, 8'h10);
        push(3'd5, 8'h20);
        ra1 = 3'd5; ra2 = 3'd6;
        #1;
        check("fwd1_hit", fwd1_hit, FWD ? 1 : 0);
        check("fwd1_data", fwd1_data, FWD ? 8'h20 : 8'h00);
        check("fwd2_hit", fwd2_hit, 0);
        check("fwd2_data", fwd2_data, 0);
        drain_en = 1'b1;
        tick();
        check("fwd1_after_pop_old", fwd1_data, FWD ? 8'h20 : 8'h00);
        check("fwd1_hit_during_drain", fwd1_hit, FWD ? 1 : 0);
        tick();
        check("fwd1_after_pop_all", fwd1_hit, 0);
        drain_en = 1'b0;
        ra1 = '0; ra2 = '0;

        // Register 0 writes are dropped
        in_valid = 1'b1; in_addr = 3'd0; in_data = 8'hFF;
        #1;
        check("r0_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        drain_en = 1'b1;
        #1;
        check("r0_count", count, 0);
        check("r0_we3", we3, 0);
        check("r0_fwd1_hit", fwd1_hit, 0);
        drain_en = 1'b0;

        // Simultaneous push/pop across pointer wrap
        push(3'd1, 8'h01); exp_q.push_back({3'd1, 8'h01});
        push(3'd2, 8'h02); exp_q.push_back({3'd2, 8'h02});
        drain_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_addr = 3'd7; in_data = 8'h70 + 8'(k);
            #1;
            ent = exp_q.pop_front();
            exp_q.push_back({3'd7, 8'h70 + 8'(k)});
            check("sim_we3", we3, 1);
            check("sim_wa3", wa3, ent[10:8]);
            check("sim_wd3", wd3, ent[7:0]);
            tick();
            check("sim_count", count, 2);
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0) begin
            #1;
            ent = exp_q.pop_front();
            check("sim_tail_wa3", wa3, ent[10:8]);
            check("sim_tail_wd3", wd3, ent[7:0]);
            tick();
        end
        check("sim_empty", empty, 1);
        drain_en = 1'b0;

        // Asynchronous reset mid-operation
        push(3'd4, 8'hC4);
        push(3'd5, 8'hC5);
        push(3'd6, 8'hC6);
        ra1 = 3'd5; ra2 = 3'd6;
        drain_en = 1'b1;
        #1;
        check("mid_we3_before", we3, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_we3", we3, 0);
        check("mid_count", count, 0);
        check("mid_fwd1_hit", fwd1_hit, 0);
        check("mid_fwd2_hit", fwd2_hit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_no_stale_we3", we3, 0);
        end
        check("mid_empty", empty, 1);
        drain_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
